load_store_unit: RTL and testbench

Sequencer between the RV32 core's execute stage and the byte-addressed data `memory` block. It takes one load or store request at a time and converts it into aligned word accesses on the memory port. Sub-word stores are done as word read-modify-write, because memory writes all four bytes at once. Loads are extracted and sign- or zero-extended per RISC-V funct3. Misaligned or illegal requests are flagged without touching memory.

---
 rtl/load_store_unit.sv | 216 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32 load/store at a time onto a word-wide,
// registered-read data memory. Sub-word stores become read-modify-write,
// loads are lane-extracted and sign/zero extended, and illegal or misaligned
// requests are answered with an error response without touching memory.
module load_store_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write,
    output logic [9:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readword
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_DATA = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Illegal funct3 for the direction, or address not aligned to the access size.
    function automatic logic is_bad(input logic wr, input logic [2:0] f3, input logic [1:0] lane);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lane[0];
            3'b010:  bad = (lane != 2'b00);
            3'b100:  bad = wr;
            3'b101:  bad = wr | lane[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = 8'd0;
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b100:  res = {24'd0, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b101:  res = {16'd0, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay the store byte/half onto the word read back from memory.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res        = word;
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        bad_s;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;

    logic        mem_write_s;
    logic [9:0]  mem_address_s;
    logic [31:0] mem_writedata_s;
    logic        resp_valid_s;
    logic        resp_error_s;
    logic [31:0] resp_rdata_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign bad_s    = is_bad(req_write, req_funct3, req_addr[1:0]);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: errors go straight to RESP, SW skips the read phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (bad_s) begin
                    state_s = ST_RESP;
                end else if (req_write && (req_funct3 == 3'b010)) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_RD:   state_s = ST_DATA;
            ST_DATA: state_s = write_r ? ST_WR : ST_RESP;
            ST_WR:   state_s = ST_RESP;
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: next values for every registered output, held unless updated.
    always_comb begin
        req_ready       = (state_r == ST_IDLE);
        mem_write_s     = (state_s == ST_WR);
        resp_valid_s    = (state_s == ST_RESP);
        mem_address_s   = mem_address;
        mem_writedata_s = mem_writedata;
        resp_error_s    = resp_error;
        resp_rdata_s    = resp_rdata;
        if (accept_s) begin
            mem_address_s = {req_addr[9:2], 2'b00};
        end else begin
            mem_address_s = mem_address;
        end
        if (accept_s && req_write && (req_funct3 == 3'b010) && !bad_s) begin
            mem_writedata_s = req_wdata;
        end else if ((state_r == ST_DATA) && write_r) begin
            mem_writedata_s = merge_store(mem_readword, wdata_r, funct3_r, lane_r);
        end else begin
            mem_writedata_s = mem_writedata;
        end
        if (state_s == ST_RESP) begin
            // Only the IDLE->RESP shortcut is an error; only loads return data.
            resp_error_s = (state_r == ST_IDLE);
            if ((state_r == ST_DATA) && !write_r) begin
                resp_rdata_s = extract_load(mem_readword, funct3_r, lane_r);
            end else begin
                resp_rdata_s = 32'd0;
            end
        end else begin
            resp_error_s = resp_error;
            resp_rdata_s = resp_rdata;
        end
    end

    // Output registers; reset drops an in-flight write and response at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_write     <= 1'b0;
            mem_address   <= 10'd0;
            mem_writedata <= 32'd0;
            resp_valid    <= 1'b0;
            resp_error    <= 1'b0;
            resp_rdata    <= 32'd0;
        end else begin
            mem_write     <= mem_write_s;
            mem_address   <= mem_address_s;
            mem_writedata <= mem_writedata_s;
            resp_valid    <= resp_valid_s;
            resp_error    <= resp_error_s;
            resp_rdata    <= resp_rdata_s;
        end
    end

    // Request field capture at the accepting edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_r  <= 1'b0;
            funct3_r <= 3'd0;
            lane_r   <= 2'd0;
            wdata_r  <= 32'd0;
        end else if (accept_s) begin
            write_r  <= req_write;
            funct3_r <= req_funct3;
            lane_r   <= req_addr[1:0];
            wdata_r  <= req_wdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a response
// scoreboard (expected data, error flag, latency and write-pulse count).
module tb_load_store_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write;
    logic [9:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readword;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:255];
    int          wr_pulses;
    int          resp_cnt;
    logic [9:0]  last_waddr;
    int          checks;
    int          errors;

    load_store_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readword  (mem_readword)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory with registered read, plus write/response bookkeeping.
    always @(posedge clock) begin
        if (mem_write) begin
            mem[mem_address[9:2]] <= mem_writedata;
            wr_pulses             <= wr_pulses + 1;
            last_waddr            <= mem_address;
        end
        if (resp_valid) begin
            resp_cnt <= resp_cnt + 1;
        end
        mem_readword <= mem[mem_address[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 10'($urandom);
        req_wdata  = $urandom;
    endtask

    // Drive one request (starting at a negedge), score its response, and end at
    // the negedge of the first IDLE cycle afterwards.
    task automatic send(input logic wr, input logic [2:0] f3, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_writes, input bit hold);
        exp_t e;
        exp_t got;
        int   n;
        int   w0;
        bit   seen;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("accept_wait", 32'(n), 32'd0);
        @(posedge clock);
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.lat    = exp_lat;
        e.writes = exp_writes;
        sb.push_back(e);
        #1;
        w0 = wr_pulses;
        if (hold) begin
            scramble();
        end else begin
            req_valid = 1'b0;
        end
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 12) begin
            @(negedge clock);
            n++;
            if (resp_valid) begin
                seen = 1'b1;
            end else if (hold) begin
                scramble();
            end
        end
        got = sb.pop_front();
        check("resp_seen", 32'(seen), 32'd1);
        check("latency", 32'(n), 32'(got.lat));
        check("resp_rdata", resp_rdata, got.rdata);
        check("resp_error", 32'(resp_error), 32'(got.err));
        check("write_pulses", 32'(wr_pulses - w0), 32'(got.writes));
        @(negedge clock);
        check("ready_after_resp", 32'(req_ready), 32'd1);
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int rc0;
        checks     = 0;
        errors     = 0;
        wr_pulses  = 0;
        resp_cnt   = 0;
        last_waddr = 10'd0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 10'd0;
        req_wdata  = 32'd0;
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_writedata", mem_writedata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // SW then LW
        send(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 1'b0);
        check("sw_addr", 32'(last_waddr), 32'h010);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        send(1'b0, 3'b010, 10'h010, 32'd0, 32'hDEADBEEF, 1'b0, 3, 0, 1'b0);

        // Preload words through the unit
        send(1'b1, 3'b010, 10'h020, 32'h80FF7F01, 32'd0, 1'b0, 2, 1, 1'b0);
        send(1'b1, 3'b010, 10'h030, 32'h11223344, 32'd0, 1'b0, 2, 1, 1'b0);

        // Sub-word loads
        send(1'b0, 3'b000, 10'h021, 32'd0, 32'h0000007F, 1'b0, 3, 0, 1'b0);
        send(1'b0, 3'b000, 10'h022, 32'd0, 32'hFFFFFFFF, 1'b0, 3, 0, 1'b0);
        send(1'b0, 3'b100, 10'h023, 32'd0, 32'h00000080, 1'b0, 3, 0, 1'b0);
        send(1'b0, 3'b001, 10'h022, 32'd0, 32'hFFFF80FF, 1'b0, 3, 0, 1'b0);
        send(1'b0, 3'b101, 10'h022, 32'd0, 32'h000080FF, 1'b0, 3, 0, 1'b0);

        // Read-modify-write
        send(1'b1, 3'b000, 10'h032, 32'hFFFFFFAA, 32'd0, 1'b0, 4, 1, 1'b0);
        check("sb_addr", 32'(last_waddr), 32'h030);
        check("sb_mem", mem[12], 32'h11AA3344);
        send(1'b1, 3'b001, 10'h030, 32'h1234BEEF, 32'd0, 1'b0, 4, 1, 1'b0);
        check("sh_mem", mem[12], 32'h11AABEEF);

        // Error requests
        send(1'b0, 3'b010, 10'h005, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0);
        send(1'b1, 3'b001, 10'h033, 32'h0000CAFE, 32'd0, 1'b1, 1, 0, 1'b0);
        send(1'b0, 3'b001, 10'h001, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0);
        send(1'b0, 3'b011, 10'h020, 32'd0, 32'd0, 1'b1, 1, 0, 1'b0);
        send(1'b1, 3'b100, 10'h030, 32'h00000055, 32'd0, 1'b1, 1, 0, 1'b0);
        check("err_mem_030", mem[12], 32'h11AABEEF);
        check("err_mem_020", mem[8], 32'h80FF7F01);

        // Handshake: valid held high with changing fields while busy, back to back
        send(1'b0, 3'b010, 10'h030, 32'd0, 32'h11AABEEF, 1'b0, 3, 0, 1'b1);
        send(1'b1, 3'b000, 10'h031, 32'h00000055, 32'd0, 1'b0, 4, 1, 1'b1);
        check("hold_sb_mem", mem[12], 32'h11AA55EF);
        send(1'b0, 3'b101, 10'h030, 32'd0, 32'h000055EF, 1'b0, 3, 0, 1'b0);
        req_valid = 1'b0;

        // Reset in the DATA cycle of a load
        rc0        = resp_cnt;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 10'h020;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("busy_before_reset", 32'(req_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_mem_write", 32'(mem_write), 32'd0);
        check("mid_rst_mem_address", 32'(mem_address), 32'd0);
        check("mid_rst_mem_writedata", mem_writedata, 32'd0);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_rdata", resp_rdata, 32'd0);
        check("mid_rst_resp_error", 32'(resp_error), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("no_resp_after_reset", 32'(resp_cnt - rc0), 32'd0);

        // Recovery after reset
        send(1'b0, 3'b010, 10'h030, 32'd0, 32'h11AA55EF, 1'b0, 3, 0, 1'b0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
